// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   - FSM state encodings (2-bit, legacy-compatible constants)
//   - clog2 helper used to size the step counter
package seq_multiplier_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Ceiling log2 for sizing counters; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_multiplier_abs.sv
// mult_abs: conditional two's-complement negate.
//   en     : 1 = output the negation of value, 0 = pass value through
//   value  : WIDTH-bit input
//   result : WIDTH-bit output, en ? -value : value
// Used both to take operand magnitudes and to re-apply the product sign.
// The most-negative input maps to itself, which read as unsigned is its
// correct magnitude.
module mult_abs #(
    parameter int WIDTH = 4
) (
    input  logic             en,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] result
);

    assign result = en ? (~value + 1'b1) : value;

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-add multiplier, one product per
// transaction, WIDTH step cycles, optional two's-complement mode.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : request, taken only on an edge where ready=1
//   is_signed       : 1 = signed operands/product, sampled with start
//   a, b            : multiplicand, multiplier (WIDTH bits)
//   ready           : high only in IDLE
//   done            : one-cycle pulse when p is updated
//   p               : 2*WIDTH-bit product, held until next completion/reset
//   state_dbg       : current FSM state (S_IDLE/S_BUSY/S_DONE)
// Handshake: a transaction is accepted on the rising edge where
// start=1 and ready=1; start at any other time is ignored. done marks
// the single cycle in which a new p first appears; there is no
// back-pressure on done.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] p,
    output logic [1:0]         state_dbg
);

    localparam int CW = clog2(WIDTH + 1);

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplr;     // multiplier; low product bits shift in from the top
    logic [WIDTH-1:0]   acc_hi;   // upper accumulator half
    logic               neg;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] next_prod;
    logic [2*WIDTH-1:0] p_next;
    logic               last_step;

    mult_abs #(.WIDTH(WIDTH)) u_abs_a (
        .en     (is_signed & a[WIDTH-1]),
        .value  (a),
        .result (a_mag)
    );

    mult_abs #(.WIDTH(WIDTH)) u_abs_b (
        .en     (is_signed & b[WIDTH-1]),
        .value  (b),
        .result (b_mag)
    );

    // One shift-add step: conditional add into the upper half, carry kept
    // in sum[WIDTH], then {carry, acc_hi, mplr} shifts right by one.
    assign sum       = {1'b0, acc_hi} + {1'b0, (mplr[0] ? mcand : {WIDTH{1'b0}})};
    assign next_prod = {sum, mplr[WIDTH-1:1]};
    assign last_step = (count == CW'(WIDTH - 1));

    // Sign is applied to the magnitude product as it is being completed,
    // so p is loaded in the same edge that ends the last step.
    mult_abs #(.WIDTH(2 * WIDTH)) u_abs_p (
        .en     (neg),
        .value  (next_prod),
        .result (p_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            count  <= '0;
            mcand  <= '0;
            mplr   <= '0;
            acc_hi <= '0;
            neg    <= 1'b0;
            p      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplr   <= b_mag;
                        acc_hi <= '0;
                        count  <= '0;
                        neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc_hi <= sum[WIDTH:1];
                    mplr   <= {sum[0], mplr[WIDTH-1:1]};
                    count  <= count + 1'b1;
                    if (last_step) begin
                        p     <= p_next;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Decoded straight from the state register; no input-to-output path.
    assign ready     = (state == S_IDLE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier at WIDTH=4 and WIDTH=8. Drivers push expected
// product and expected done cycle; per-instance monitors pop on done.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=4 instance
  logic       start4 = 1'b0, s4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ready4, done4;
  logic [7:0] p4;
  logic [1:0] st4;

  // WIDTH=8 instance
  logic       start8 = 1'b0, s8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, done8;
  logic [15:0] p8;
  logic [1:0] st8;

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .is_signed(s4), .a(a4), .b(b4),
    .ready(ready4), .done(done4), .p(p4), .state_dbg(st4)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(s8), .a(a8), .b(b8),
    .ready(ready8), .done(done8), .p(p8), .state_dbg(st8)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp_q4[$];
  int          exp_t4[$];
  logic [15:0] exp_q8[$];
  int          exp_t8[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: interpret operands as w-bit integers, multiply, keep 2w bits.
  function automatic logic [15:0] model(input int w, input logic [7:0] a,
                                        input logic [7:0] b, input bit s);
    longint x, y, prod, mask;
    x = longint'(a) & ((longint'(1) << w) - 1);
    y = longint'(b) & ((longint'(1) << w) - 1);
    if (s && x[w-1]) x = x - (longint'(1) << w);
    if (s && y[w-1]) y = y - (longint'(1) << w);
    prod = x * y;
    mask = (longint'(1) << (2 * w)) - 1;
    return 16'(prod & mask);
  endfunction

  // ---------------- monitors ----------------
  bit chk_ready4 = 0;
  bit chk_ready8 = 0;

  always @(negedge clk) begin
    logic [15:0] e;
    int t;
    if (!rst) begin
      if (chk_ready4) begin
        check("ready_after_done4", {15'd0, ready4}, 16'd1);
        chk_ready4 = 0;
      end
      if (done4) begin
        if (exp_q4.size() == 0) begin
          check("unexpected_done4", {8'd0, p4}, 16'hxxxx);
        end else begin
          e = exp_q4.pop_front();
          t = exp_t4.pop_front();
          check("product4", {8'd0, p4}, e);
          check("latency4", 16'(cyc), 16'(t));
          check("ready_low_in_done4", {15'd0, ready4}, 16'd0);
        end
        chk_ready4 = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] e;
    int t;
    if (!rst) begin
      if (chk_ready8) begin
        check("ready_after_done8", {15'd0, ready8}, 16'd1);
        chk_ready8 = 0;
      end
      if (done8) begin
        if (exp_q8.size() == 0) begin
          check("unexpected_done8", p8, 16'hxxxx);
        end else begin
          e = exp_q8.pop_front();
          t = exp_t8.pop_front();
          check("product8", p8, e);
          check("latency8", 16'(cyc), 16'(t));
          check("ready_low_in_done8", {15'd0, ready8}, 16'd0);
        end
        chk_ready8 = 1;
      end
    end
  end

  // ---------------- drivers ----------------
  // Returns at the negedge after the accepting edge (DUT is in BUSY).
  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input bit s, input bit push);
    int n;
    @(negedge clk);
    n = 0;
    while (!ready4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready4) check("timeout_ready4", {15'd0, ready4}, 16'd1);
    a4 = a; b4 = b; s4 = s; start4 = 1'b1;
    if (push) begin
      exp_q4.push_back(model(4, {4'd0, a}, {4'd0, b}, s));
      exp_t4.push_back(cyc + 1 + 4);
    end
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit s);
    int n;
    @(negedge clk);
    n = 0;
    while (!ready8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready8) check("timeout_ready8", {15'd0, ready8}, 16'd1);
    a8 = a; b8 = b; s8 = s; start8 = 1'b1;
    exp_q8.push_back(model(8, a, b, s));
    exp_t8.push_back(cyc + 1 + 8);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
  endtask

  logic [3:0] leg_a[10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
  logic [3:0] leg_b[10] = '{4'd0, 4'd5, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10, 4'd12, 4'd11, 4'd1};

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ready4", {15'd0, ready4}, 16'd1);
    check("reset_done4", {15'd0, done4}, 16'd0);
    check("reset_p4", {8'd0, p4}, 16'd0);
    check("reset_ready8", {15'd0, ready8}, 16'd1);
    check("reset_p8", p8, 16'd0);
    rst = 1'b0;

    // Directed WIDTH=4
    issue4(4'd15, 4'd15, 1'b0, 1'b1);
    issue4(4'hD, 4'd5, 1'b1, 1'b1);
    issue4(4'h8, 4'h8, 1'b1, 1'b1);
    issue4(4'h8, 4'd7, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) issue4(leg_a[i], leg_b[i], 1'b0, 1'b1);

    // Start pulses during BUSY must be ignored
    issue4(4'd6, 4'd7, 1'b0, 1'b1);
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd3;
    repeat (3) @(negedge clk);
    start4 = 1'b0;

    // Reset mid-BUSY at count=2: no done, cleared outputs
    issue4(4'd9, 4'd9, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready4", {15'd0, ready4}, 16'd1);
    check("midrst_done4", {15'd0, done4}, 16'd0);
    check("midrst_p4", {8'd0, p4}, 16'd0);
    check("midrst_state4", {14'd0, st4}, 16'd0);
    rst = 1'b0;
    issue4(4'd2, 4'd3, 1'b0, 1'b1);

    // Random WIDTH=4
    for (int i = 0; i < 30; i++)
      issue4(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 1'b1);

    // WIDTH=8
    issue8(8'd255, 8'd255, 1'b0);
    issue8(8'h80, 8'h80, 1'b1);
    for (int i = 0; i < 30; i++)
      issue8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    // Drain
    n = 0;
    while ((exp_q4.size() != 0 || exp_q8.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("drain_q4", 16'(exp_q4.size()), 16'd0);
    check("drain_q8", 16'(exp_q8.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
